camera_spi_register_bank: RTL and testbench
===========================================

Name: camera_spi_register_bank

Overview:
- Parametrised next-generation SPI register/command decoder for the camera subsystem.
- Sits between the SPI target byte interface and the camera capture, compression and metering logic.
- Generalises image address width, resolution width and metering channel count.
- Adds a capture state machine with busy/ready status, multi-byte MSB-first responses sized by parameter, and saturating image readout that returns 0x00 past the end of the image.

Parameters:
ADDRESS_WIDTH, 16, width of image size and image address; bytes-available response is AB = ceil(ADDRESS_WIDTH/8) bytes
RESOLUTION_WIDTH, 10, width of half_resolution_out; zoom write is RB = ceil(RESOLUTION_WIDTH/8) bytes
RESOLUTION_DEFAULT, 256, reset value of half_resolution_out
METERING_CHANNELS, 6, number of 8-bit metering values readable via 0x25

Ports:
clock_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
op_code_in  input  8  current SPI opcode
op_code_valid_in  input  1  high for the duration of a transaction
operand_in  input  8  current operand byte
operand_valid_in  input  1  high while operand_in is valid
operand_count_in  input  8  index of current operand byte within the transaction, 0-based
response_out  output  8  read-back byte
response_valid_out  output  1  response_out valid
start_capture_out  output  1  one-cycle capture start pulse
half_resolution_out  output  RESOLUTION_WIDTH  zoom setting
compression_factor_out  output  2  compression setting
power_save_enable_out  output  1  power save control
image_ready_in  input  1  image fully captured and compressed
image_total_size_in  input  ADDRESS_WIDTH  compressed image size in bytes
image_data_in  input  8  byte at image_address_out
image_address_out  output  ADDRESS_WIDTH  image buffer read address
metering_in  input  8*METERING_CHANNELS  channel i at bits [8i+7:8i]

Behaviour:
- Clocking and reset: one clock, clock_in; reset_in is synchronous, active-high.
- Reset values: response_out=0, response_valid_out=0, start_capture_out=0, half_resolution_out=RESOLUTION_DEFAULT, compression_factor_out=0, power_save_enable_out=0, image_address_out=0, state=IDLE.
- Reset mid-transaction discards that transaction; decoding resumes on the next cycle with op_code_valid_in high.
- Registered outputs: all outputs are registered, with one-cycle latency from inputs.
- op_code_valid_in low: response_valid_out=0 and start_capture_out=0 on the next edge.
- Read opcodes (0x21, 0x22, 0x25, 0x27): response_valid_out=1 on the cycle after op_code_valid_in is high.
- Capture state machine, states IDLE, CAPTURING, READY:
  - 0x20 in IDLE or READY: start_capture_out=1 for exactly one cycle per transaction (edge of op_code_valid_in, not level); image_address_out=0; goes to CAPTURING.
  - 0x20 in CAPTURING: ignored, no pulse, address unchanged.
  - CAPTURING -> READY when image_ready_in=1 on a cycle after the cycle start_capture_out was high.
  - 0x20 and image_ready_in arriving in the same cycle as the transition: the 0x20 wins and the state stays CAPTURING.
- 0x21 bytes available: remaining = image_total_size_in - image_address_out, in ADDRESS_WIDTH bits.
  - Byte k = operand_count_in, for k<AB, is byte (AB-1-k) of remaining, zero-extended to AB*8 bits (MSB first).
  - k>=AB returns 0x00.
- 0x22 read data:
  - response_out = image_data_in if image_address_out < image_total_size_in, else 0x00.
  - Address increments on each rising edge of operand_valid_in (registered edge detect).
  - Address saturates at image_total_size_in and never wraps.
- 0x23 zoom: on operand_valid_in with count c in 1..RB, byte (RB-c) of an RB*8-bit shadow register is loaded.
  - Count 0 and c>RB are ignored.
  - half_resolution_out takes the low RESOLUTION_WIDTH bits of the shadow on every write; upper bits are discarded.
- 0x25 metering: count i<METERING_CHANNELS returns channel i; otherwise 0x00.
- 0x26: on operand_valid_in, compression_factor_out=operand_in[1:0].
- 0x27 status: response_out={6'b0, state==CAPTURING, state==READY}.
- 0x28: on operand_valid_in, power_save_enable_out=operand_in[0].
- Unknown opcodes: no state change, response_valid_out stays 0.

Test Plan:
- Reset: hold reset_in 2 cycles -> half_resolution_out=256, all other outputs 0, 0x27 returns 0x00.
- Capture flow: send 0x20 held 5 cycles -> start_capture_out high exactly 1 cycle, 0x27 returns 0x02. Pulse image_ready_in -> 0x27 returns 0x01. Send 0x20 while CAPTURING -> no pulse.
- Bytes available (ADDRESS_WIDTH=20): total=0x12345, address 0 -> counts 0,1,2 return 0x01,0x23,0x45, count 3 returns 0x00.
- Readout saturation: total=3, send 0x22 with 5 operand strobes, data[0..2]=0xA0,0xA1,0xA2 -> responses 0xA0,0xA1,0xA2,0x00,0x00; address stops at 3; 0x21 returns 0x0000.
- Zoom (RESOLUTION_WIDTH=10): 0x23 operands 0xFF,0x03,0x20 -> half_resolution_out=0x320. Extra count-3 byte -> unchanged.
- Metering (METERING_CHANNELS=8): channels 0x10..0x17 -> counts 0..7 return 0x10..0x17, count 8 returns 0x00. Reset asserted mid-read -> response_valid_out=0 next cycle.

Source files
------------

// File: rtl/camera_spi_register_bank.sv
// SPI opcode decoder and register bank for the camera: capture FSM, image readout, zoom/compression/metering access.
// Every output is registered one cycle after its inputs; there is no backpressure, and a read byte is offered on each cycle of a read opcode.
module camera_spi_register_bank #(
  parameter int ADDRESS_WIDTH      = 16,
  parameter int RESOLUTION_WIDTH   = 10,
  parameter int RESOLUTION_DEFAULT = 256,
  parameter int METERING_CHANNELS  = 6
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic [7:0]                     op_code_in,
  input  logic                           op_code_valid_in,
  input  logic [7:0]                     operand_in,
  input  logic                           operand_valid_in,
  input  logic [7:0]                     operand_count_in,
  output logic [7:0]                     response_out,
  output logic                           response_valid_out,
  output logic                           start_capture_out,
  output logic [RESOLUTION_WIDTH-1:0]    half_resolution_out,
  output logic [1:0]                     compression_factor_out,
  output logic                           power_save_enable_out,
  input  logic                           image_ready_in,
  input  logic [ADDRESS_WIDTH-1:0]       image_total_size_in,
  input  logic [7:0]                     image_data_in,
  output logic [ADDRESS_WIDTH-1:0]       image_address_out,
  input  logic [8*METERING_CHANNELS-1:0] metering_in
);

  localparam int AB = (ADDRESS_WIDTH + 7) / 8;
  localparam int RB = (RESOLUTION_WIDTH + 7) / 8;

  localparam logic [7:0] OP_CAPTURE  = 8'h20;
  localparam logic [7:0] OP_AVAIL    = 8'h21;
  localparam logic [7:0] OP_READ     = 8'h22;
  localparam logic [7:0] OP_ZOOM     = 8'h23;
  localparam logic [7:0] OP_METER    = 8'h25;
  localparam logic [7:0] OP_COMPRESS = 8'h26;
  localparam logic [7:0] OP_STATUS   = 8'h27;
  localparam logic [7:0] OP_POWER    = 8'h28;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURING = 2'd1, READY = 2'd2} state_t;

  state_t                  state, state_next;
  logic                    op_code_valid_q, operand_valid_q;
  logic                    txn_start, capture_req, capture_start;
  logic                    rd_strobe, zoom_wr, addr_in_range;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [AB*8-1:0]         remaining_ext;
  logic [RB*8-1:0]         shadow, shadow_next;
  logic                    resp_vld_next;
  logic [7:0]              resp_dat_next;

  assign txn_start     = op_code_valid_in & ~op_code_valid_q;
  assign capture_req   = txn_start && (op_code_in == OP_CAPTURE);
  assign rd_strobe     = op_code_valid_in && (op_code_in == OP_READ) && operand_valid_in && !operand_valid_q;
  assign zoom_wr       = op_code_valid_in && (op_code_in == OP_ZOOM) && operand_valid_in;
  assign addr_in_range = image_address_out < image_total_size_in;
  assign remaining     = addr_in_range ? image_total_size_in - image_address_out : '0;

  always_ff @(posedge clock_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // A new capture request outranks a same-cycle image_ready, and the pulse cycle itself never completes a capture.
  always_comb begin
    state_next    = state;
    capture_start = 1'b0;
    case (state)
      IDLE, READY: begin
        if (capture_req) begin
          state_next    = CAPTURING;
          capture_start = 1'b1;
        end
      end
      CAPTURING: begin
        if (image_ready_in && !start_capture_out && !capture_req) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shadow_next = shadow;
    if (zoom_wr) begin
      for (int c = 1; c <= RB; c++) begin
        if (operand_count_in == 8'(c)) shadow_next[(RB-c)*8 +: 8] = operand_in;
      end
    end
  end

  always_comb begin
    remaining_ext                    = '0;
    remaining_ext[ADDRESS_WIDTH-1:0] = remaining;
  end

  always_comb begin
    resp_vld_next = 1'b0;
    resp_dat_next = 8'h00;
    if (op_code_valid_in) begin
      case (op_code_in)
        OP_AVAIL: begin
          resp_vld_next = 1'b1;
          for (int b = 0; b < AB; b++) begin
            if (operand_count_in == 8'(b)) resp_dat_next = remaining_ext[(AB-1-b)*8 +: 8];
          end
        end
        OP_READ: begin
          resp_vld_next = 1'b1;
          if (addr_in_range) resp_dat_next = image_data_in;
        end
        OP_METER: begin
          resp_vld_next = 1'b1;
          for (int i = 0; i < METERING_CHANNELS; i++) begin
            if (operand_count_in == 8'(i)) resp_dat_next = metering_in[i*8 +: 8];
          end
        end
        OP_STATUS: begin
          resp_vld_next = 1'b1;
          resp_dat_next = {6'b0, state == CAPTURING, state == READY};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      op_code_valid_q        <= 1'b0;
      operand_valid_q        <= 1'b0;
      response_out           <= 8'h00;
      response_valid_out     <= 1'b0;
      start_capture_out      <= 1'b0;
      shadow                 <= (RB*8)'(RESOLUTION_DEFAULT);
      half_resolution_out    <= RESOLUTION_WIDTH'(RESOLUTION_DEFAULT);
      compression_factor_out <= 2'b00;
      power_save_enable_out  <= 1'b0;
      image_address_out      <= '0;
    end else begin
      op_code_valid_q    <= op_code_valid_in;
      operand_valid_q    <= operand_valid_in;
      response_out       <= resp_dat_next;
      response_valid_out <= resp_vld_next;
      start_capture_out  <= capture_start;
      if (zoom_wr) begin
        shadow              <= shadow_next;
        half_resolution_out <= shadow_next[RESOLUTION_WIDTH-1:0];
      end
      if (op_code_valid_in && op_code_in == OP_COMPRESS && operand_valid_in)
        compression_factor_out <= operand_in[1:0];
      if (op_code_valid_in && op_code_in == OP_POWER && operand_valid_in)
        power_save_enable_out <= operand_in[0];
      // Readout address stops at the image size so trailing reads return zero.
      if (capture_start)
        image_address_out <= '0;
      else if (rd_strobe && addr_in_range)
        image_address_out <= image_address_out + ADDRESS_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_camera_spi_register_bank.sv
// Self-checking bench for camera_spi_register_bank with 20-bit addresses and 8 metering channels.
module tb_camera_spi_register_bank;

  localparam int AW = 20;
  localparam int RW = 10;
  localparam int MC = 8;

  logic          clk;
  logic          reset_in;
  logic [7:0]    op_code_in;
  logic          op_code_valid_in;
  logic [7:0]    operand_in;
  logic          operand_valid_in;
  logic [7:0]    operand_count_in;
  logic [7:0]    response_out;
  logic          response_valid_out;
  logic          start_capture_out;
  logic [RW-1:0] half_resolution_out;
  logic [1:0]    compression_factor_out;
  logic          power_save_enable_out;
  logic          image_ready_in;
  logic [AW-1:0] image_total_size_in;
  logic [7:0]    image_data_in;
  logic [AW-1:0] image_address_out;
  logic [8*MC-1:0] metering_in;

  logic [7:0] img_mem [0:15];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int n_cmp;
  int n_bad;

  camera_spi_register_bank #(
    .ADDRESS_WIDTH(AW), .RESOLUTION_WIDTH(RW), .RESOLUTION_DEFAULT(256), .METERING_CHANNELS(MC)
  ) dut (
    .clock_in(clk), .reset_in(reset_in),
    .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in), .operand_count_in(operand_count_in),
    .response_out(response_out), .response_valid_out(response_valid_out),
    .start_capture_out(start_capture_out), .half_resolution_out(half_resolution_out),
    .compression_factor_out(compression_factor_out), .power_save_enable_out(power_save_enable_out),
    .image_ready_in(image_ready_in), .image_total_size_in(image_total_size_in),
    .image_data_in(image_data_in), .image_address_out(image_address_out),
    .metering_in(metering_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image buffer model: unwritten locations hold recognisable non-zero bytes.
  always_comb image_data_in = (image_address_out < AW'(16)) ? img_mem[image_address_out[3:0]] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic opv, input logic [7:0] cnt,
                       input logic [7:0] opd, input logic odv);
    op_code_in       = op;
    op_code_valid_in = opv;
    operand_count_in = cnt;
    operand_in       = opd;
    operand_valid_in = odv;
  endtask

  task automatic idle_cycle();
    drive(8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    n_cmp++;
    if (half_resolution_out !== 10'h100) begin n_bad++; $display("FAIL reset_half_res: got %h want 100", half_resolution_out); end
    n_cmp++;
    if ({response_out, response_valid_out, start_capture_out, compression_factor_out, power_save_enable_out} !== 13'h0 ||
        image_address_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: resp %h vld %b start %b comp %b pse %b addr %h, want all zero",
               response_out, response_valid_out, start_capture_out, compression_factor_out,
               power_save_enable_out, image_address_out);
    end
    reset_in = 1'b0;
    drive(8'h27, 1'b1, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'h00);
    step();
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
      n_bad++; $display("FAIL reset_status: vld %b got %h want %h", response_valid_out, response_out, exp_b);
    end
    idle_cycle();
  endtask

  task automatic test_capture();
    int pulses;
    int first;
    logic [7:0] status_exp [4] = '{8'h02, 8'h01, 8'h02, 8'h02};
    // Held 0x20 transaction: single pulse on the first cycle only.
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 5; i++) begin
      drive(8'h20, 1'b1, 8'h00, 8'h00, 1'b0);
      step();
      if (start_capture_out === 1'b1) begin pulses++; if (first < 0) first = i; end
    end
    idle_cycle();
    if (start_capture_out === 1'b1) pulses++;
    n_cmp++;
    if (pulses !== 1 || first !== 0) begin n_bad++; $display("FAIL capture_pulse: %0d pulses first at %0d, want 1 at 0", pulses, first); end
    n_cmp++;
    if (image_address_out !== '0) begin n_bad++; $display("FAIL capture_addr: got %h want 0", image_address_out); end

    for (int s = 0; s < 4; s++) begin
      case (s)
        1: begin
          // Repeat request while capturing gives no pulse; then ready completes the capture.
          pulses = 0;
          for (int i = 0; i < 3; i++) begin
            drive(8'h20, 1'b1, 8'h00, 8'h00, 1'b0);
            step();
            if (start_capture_out === 1'b1) pulses++;
          end
          idle_cycle();
          n_cmp++;
          if (pulses !== 0) begin n_bad++; $display("FAIL capture_ignored: %0d pulses want 0", pulses); end
          image_ready_in = 1'b1;
          step();
          image_ready_in = 1'b0;
        end
        2: begin
          // Ready during the pulse cycle must not complete the new capture.
          drive(8'h20, 1'b1, 8'h00, 8'h00, 1'b0);
          step();
          n_cmp++;
          if (start_capture_out !== 1'b1) begin n_bad++; $display("FAIL recapture_pulse: got %b want 1", start_capture_out); end
          image_ready_in = 1'b1;
          step();
          image_ready_in = 1'b0;
          idle_cycle();
        end
        3: begin
          // Capture request and ready together: state stays CAPTURING.
          drive(8'h20, 1'b1, 8'h00, 8'h00, 1'b0);
          image_ready_in = 1'b1;
          step();
          image_ready_in = 1'b0;
          idle_cycle();
        end
        default: ;
      endcase
      drive(8'h27, 1'b1, 8'h00, 8'h00, 1'b0);
      exp_q.push_back(status_exp[s]);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL capture_status step %0d: vld %b got %h want %h", s, response_valid_out, response_out, exp_b);
      end
      idle_cycle();
    end
    image_ready_in = 1'b1;
    step();
    image_ready_in = 1'b0;
    drive(8'h27, 1'b1, 8'h00, 8'h00, 1'b0);
    exp_q.push_back(8'h01);
    step();
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
      n_bad++; $display("FAIL ready_status: vld %b got %h want %h", response_valid_out, response_out, exp_b);
    end
    idle_cycle();
  endtask

  task automatic test_bytes_available();
    logic [7:0] exp_avail [4] = '{8'h01, 8'h23, 8'h45, 8'h00};
    image_total_size_in = 20'h12345;
    for (int k = 0; k < 4; k++) begin
      drive(8'h21, 1'b1, 8'(k), 8'h00, 1'b0);
      exp_q.push_back(exp_avail[k]);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL avail k=%0d: vld %b got %h want %h", k, response_valid_out, response_out, exp_b);
      end
    end
    idle_cycle();
  endtask

  task automatic test_readout();
    logic [7:0] strobe_exp [5] = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00};
    logic [7:0] gap_exp    [5] = '{8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00};
    image_total_size_in = 20'd3;
    for (int j = 0; j < 5; j++) begin
      drive(8'h22, 1'b1, 8'(j), 8'h00, 1'b1);
      exp_q.push_back(strobe_exp[j]);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL read_strobe j=%0d: vld %b got %h want %h", j, response_valid_out, response_out, exp_b);
      end
      operand_valid_in = 1'b0;
      exp_q.push_back(gap_exp[j]);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL read_gap j=%0d: vld %b got %h want %h", j, response_valid_out, response_out, exp_b);
      end
    end
    n_cmp++;
    if (image_address_out !== AW'(3)) begin n_bad++; $display("FAIL read_addr_sat: got %h want 3", image_address_out); end
    idle_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(8'h21, 1'b1, 8'(k), 8'h00, 1'b0);
      exp_q.push_back(8'h00);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL avail_empty k=%0d: vld %b got %h want %h", k, response_valid_out, response_out, exp_b);
      end
    end
    idle_cycle();
  endtask

  task automatic test_zoom_and_controls();
    logic [7:0] zoom_opd [4] = '{8'hFF, 8'h03, 8'h20, 8'h55};
    logic [9:0] zoom_exp [4] = '{10'h100, 10'h300, 10'h320, 10'h320};
    for (int c = 0; c < 4; c++) begin
      drive(8'h23, 1'b1, 8'(c), zoom_opd[c], 1'b1);
      step();
      n_cmp++;
      if (half_resolution_out !== zoom_exp[c] || response_valid_out !== 1'b0) begin
        n_bad++; $display("FAIL zoom c=%0d: half_res %h vld %b want %h vld 0", c, half_resolution_out, response_valid_out, zoom_exp[c]);
      end
    end
    idle_cycle();
    drive(8'h26, 1'b1, 8'h00, 8'hFE, 1'b1);
    step();
    idle_cycle();
    n_cmp++;
    if (compression_factor_out !== 2'b10) begin n_bad++; $display("FAIL compression: got %b want 10", compression_factor_out); end
    drive(8'h28, 1'b1, 8'h00, 8'h01, 1'b1);
    step();
    idle_cycle();
    n_cmp++;
    if (power_save_enable_out !== 1'b1) begin n_bad++; $display("FAIL power_save: got %b want 1", power_save_enable_out); end
    drive(8'h30, 1'b1, 8'h01, 8'h03, 1'b1);
    step();
    n_cmp++;
    if (response_valid_out !== 1'b0 || half_resolution_out !== 10'h320 || compression_factor_out !== 2'b10 ||
        power_save_enable_out !== 1'b1) begin
      n_bad++; $display("FAIL unknown_op: vld %b half_res %h comp %b pse %b, want 0 320 10 1",
                        response_valid_out, half_resolution_out, compression_factor_out, power_save_enable_out);
    end
    idle_cycle();
  endtask

  task automatic test_metering_and_reset();
    for (int i = 0; i < MC; i++) metering_in[i*8 +: 8] = 8'(8'h10 + i);
    for (int k = 0; k <= MC; k++) begin
      drive(8'h25, 1'b1, 8'(k), 8'h00, 1'b0);
      exp_q.push_back((k < MC) ? 8'(8'h10 + k) : 8'h00);
      step();
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
        n_bad++; $display("FAIL meter k=%0d: vld %b got %h want %h", k, response_valid_out, response_out, exp_b);
      end
    end
    drive(8'h25, 1'b1, 8'h02, 8'h00, 1'b0);
    reset_in = 1'b1;
    step();
    n_cmp++;
    if (response_valid_out !== 1'b0 || half_resolution_out !== 10'h100) begin
      n_bad++; $display("FAIL midread_reset: vld %b half_res %h, want 0 100", response_valid_out, half_resolution_out);
    end
    reset_in = 1'b0;
    drive(8'h25, 1'b1, 8'h03, 8'h00, 1'b0);
    exp_q.push_back(8'h13);
    step();
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (response_valid_out !== 1'b1 || response_out !== exp_b) begin
      n_bad++; $display("FAIL after_reset_read: vld %b got %h want %h", response_valid_out, response_out, exp_b);
    end
    idle_cycle();
    n_cmp++;
    if (exp_q.size() != 0 || response_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left, vld %b, want 0 left vld 0", exp_q.size(), response_valid_out);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    image_ready_in      = 1'b0;
    image_total_size_in = '0;
    metering_in         = '0;
    for (int i = 0; i < 16; i++) img_mem[i] = 8'(8'hA0 + i);
    test_reset();
    test_capture();
    test_bytes_available();
    test_readout();
    test_zoom_and_controls();
    test_metering_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
